// File: rtl/mc14500_pkg.sv
// Shared constants for the MC14500B ICU and its program sequencer:
// opcodes, ICU phase encoding, program-word field layout.
package mc14500_pkg;

    localparam logic [3:0] OPC_NOPO = 4'h0;
    localparam logic [3:0] OPC_LD   = 4'h1;
    localparam logic [3:0] OPC_LDC  = 4'h2;
    localparam logic [3:0] OPC_AND  = 4'h3;
    localparam logic [3:0] OPC_ANDC = 4'h4;
    localparam logic [3:0] OPC_OR   = 4'h5;
    localparam logic [3:0] OPC_ORC  = 4'h6;
    localparam logic [3:0] OPC_XNOR = 4'h7;
    localparam logic [3:0] OPC_STO  = 4'h8;
    localparam logic [3:0] OPC_STOC = 4'h9;
    localparam logic [3:0] OPC_IEN  = 4'hA;
    localparam logic [3:0] OPC_OEN  = 4'hB;
    localparam logic [3:0] OPC_JMP  = 4'hC;
    localparam logic [3:0] OPC_RTN  = 4'hD;
    localparam logic [3:0] OPC_SKZ  = 4'hE;
    localparam logic [3:0] OPC_NOPF = 4'hF;

    // ICU state_out encoding
    localparam logic ST_FETCH          = 1'b0;
    localparam logic ST_DECODE_EXECUTE = 1'b1;

    // Program word layout: opcode in the low nibble, operand above it
    localparam int OPC_LSB     = 0;
    localparam int OPC_W       = 4;
    localparam int OPERAND_LSB = 4;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'd0,
        PC_JUMP = 2'd1,
        PC_POP  = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/mc14500b_rstack.sv
// Return-address LIFO for the MC14500B sequencer, with sticky
// overflow/underflow flags. Push and pop are never requested together.
module mc14500b_rstack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                           clk_in,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [ADDR_W-1:0]              push_data,
    output logic [ADDR_W-1:0]              top,
    output logic                           empty,
    output logic                           ovf,
    output logic                           unf,
    output logic [$clog2(STACK_DEPTH):0]   sp
);

    localparam int PTR_W = $clog2(STACK_DEPTH);

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [PTR_W:0]    sp_q;
    logic [PTR_W-1:0]  wr_idx;
    logic [PTR_W-1:0]  top_idx;
    logic              full;

    assign full    = (sp_q == (PTR_W+1)'(STACK_DEPTH));
    assign empty   = (sp_q == '0);
    assign wr_idx  = sp_q[PTR_W-1:0];
    // When full the low pointer bits wrap to 0, so minus one still lands on the last entry
    assign top_idx = sp_q[PTR_W-1:0] - 1'b1;
    assign top     = mem[top_idx];
    assign sp      = sp_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else if (push) begin
            if (full) ovf  <= 1'b1;
            else      sp_q <= sp_q + 1'b1;
        end else if (pop) begin
            if (empty) unf  <= 1'b1;
            else       sp_q <= sp_q - 1'b1;
        end
    end

    // NOTE: the entry storage is deliberately left out of reset; with sp
    // cleared nothing above the pointer is ever read, so resetting it buys nothing.
    always_ff @(posedge clk_in) begin
        if (push && !full) mem[wr_idx] <= push_data;
    end

endmodule

// File: rtl/mc14500b_seq.sv
// Program sequencer for the MC14500B ICU: PC, opcode/operand split,
// JMP/RTN resolution with delay slot and a NOPF-marked call stack.
module mc14500b_seq
    import mc14500_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                           clk_in,
    input  logic                           rst,
    output logic [ADDR_W-1:0]              prog_addr,
    input  logic [4+ADDR_W-1:0]            prog_data,
    output logic [3:0]                     I,
    output logic [ADDR_W-1:0]              io_addr,
    input  logic                           icu_state,
    input  logic                           jmp,
    input  logic                           rtn,
    input  logic                           flgf,
    output logic                           stack_ovf,
    output logic                           stack_unf,
    output logic [$clog2(STACK_DEPTH):0]   sp_dbg
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] io_q;
    logic [ADDR_W-1:0] tgt_q;
    logic              call_pending_q;

    logic [ADDR_W-1:0] operand;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] stack_top;
    logic              stack_empty;
    logic              fetch_en;
    logic              push;
    logic              pop;
    pc_sel_e           pc_sel;

    assign fetch_en  = (icu_state == ST_FETCH);
    assign operand   = prog_data[OPERAND_LSB +: ADDR_W];
    assign I         = prog_data[OPC_LSB +: OPC_W];
    assign pc_plus1  = pc_q + 1'b1;
    assign prog_addr = pc_q;
    assign io_addr   = io_q;

    // NOTE: every output of this block is given a default before any branch,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        pc_sel = PC_SEQ;
        push   = 1'b0;
        pop    = 1'b0;
        if (rtn) begin
            // rtn outranks jmp; an empty stack falls through to pc+1 and flags underflow
            pop    = fetch_en;
            pc_sel = stack_empty ? PC_SEQ : PC_POP;
        end else if (jmp) begin
            pc_sel = PC_JUMP;
            push   = fetch_en && call_pending_q;
        end
    end

    always_comb begin
        next_pc = pc_plus1;
        unique case (pc_sel)
            PC_JUMP: next_pc = tgt_q;
            PC_POP:  next_pc = stack_top;
            default: next_pc = pc_plus1;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values (tgt_q must still hold the JMP operand here).
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            pc_q           <= '0;
            io_q           <= '0;
            tgt_q          <= '0;
            call_pending_q <= 1'b0;
        end else if (fetch_en) begin
            pc_q           <= next_pc;
            io_q           <= operand;
            tgt_q          <= operand;
            // A call marker lives exactly one fetch: the push consumes it or it lapses
            call_pending_q <= flgf;
        end
    end

    mc14500b_rstack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_rstack (
        .clk_in    (clk_in),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus1),
        .top       (stack_top),
        .empty     (stack_empty),
        .ovf       (stack_ovf),
        .unf       (stack_unf),
        .sp        (sp_dbg)
    );

endmodule

// File: tb/tb_mc14500b_seq.sv
// Directed bench for mc14500b_seq: a table of fetch/execute instruction
// steps with hand-computed PC/stack results, plus reset and hold sequences.
module tb_mc14500b_seq;
    import mc14500_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst;
    logic [7:0]  prog_addr;
    logic [11:0] prog_data;
    logic [3:0]  I;
    logic [7:0]  io_addr;
    logic        icu_state;
    logic        jmp;
    logic        rtn;
    logic        flgf;
    logic        stack_ovf;
    logic        stack_unf;
    logic [2:0]  sp_dbg;

    logic [11:0] pmem [256];
    assign prog_data = pmem[prog_addr];

    always #5 clk_in = ~clk_in;

    mc14500b_seq #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .I         (I),
        .io_addr   (io_addr),
        .icu_state (icu_state),
        .jmp       (jmp),
        .rtn       (rtn),
        .flgf      (flgf),
        .stack_ovf (stack_ovf),
        .stack_unf (stack_unf),
        .sp_dbg    (sp_dbg)
    );

    // One instruction: flags seen on the FETCH edge, results after it
    typedef struct packed {
        logic       jmp;
        logic       rtn;
        logic       flgf;
        logic [7:0] fetched;
        logic [7:0] pc;
        logic [2:0] sp;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic v(input logic j, input logic r, input logic f, input logic [7:0] fa,
                     input logic [7:0] pc, input logic [2:0] sp, input logic o, input logic u);
        vecs.push_back({j, r, f, fa, pc, sp, o, u});
    endtask

    task automatic setw(input logic [7:0] a, input logic [3:0] opc, input logic [7:0] opnd);
        pmem[a] = {opnd, opc};
    endtask

    task automatic step(input logic st, input logic j, input logic r, input logic f);
        @(negedge clk_in);
        icu_state = st;
        jmp       = j;
        rtn       = r;
        flgf      = f;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst = 1'b1; icu_state = 1'b1; jmp = 1'b0; rtn = 1'b0; flgf = 1'b0;
        for (int a = 0; a < 256; a++) pmem[a] = {8'(a) ^ 8'hA5, OPC_LD};
        setw(8'h03, OPC_JMP,  8'h10);
        setw(8'h10, OPC_JMP,  8'h40);
        setw(8'h40, OPC_JMP,  8'h20);
        setw(8'h20, OPC_NOPF, 8'h00);
        setw(8'h21, OPC_JMP,  8'h80);
        setw(8'h85, OPC_RTN,  8'h00);
        setw(8'h23, OPC_NOPF, 8'h00);
        setw(8'h24, OPC_JMP,  8'h30);
        setw(8'h30, OPC_NOPF, 8'h00);
        setw(8'h31, OPC_JMP,  8'h50);
        setw(8'h50, OPC_NOPF, 8'h00);
        setw(8'h51, OPC_JMP,  8'h60);
        setw(8'h60, OPC_NOPF, 8'h00);
        setw(8'h61, OPC_JMP,  8'h70);
        setw(8'h70, OPC_NOPF, 8'h00);
        setw(8'h71, OPC_JMP,  8'hFE);

        //  j  r  f  fetched pc     sp ovf unf
        v(0, 0, 0, 8'h00, 8'h01, 0, 0, 0);
        v(0, 0, 0, 8'h01, 8'h02, 0, 0, 0);
        v(0, 0, 0, 8'h02, 8'h03, 0, 0, 0);
        v(0, 0, 0, 8'h03, 8'h04, 0, 0, 0);
        v(1, 0, 0, 8'h04, 8'h10, 0, 0, 0);
        v(0, 0, 0, 8'h10, 8'h11, 0, 0, 0);
        v(1, 0, 0, 8'h11, 8'h40, 0, 0, 0);   // plain jump: delay slot 0x11, no push
        v(0, 0, 0, 8'h40, 8'h41, 0, 0, 0);
        v(1, 0, 0, 8'h41, 8'h20, 0, 0, 0);
        v(0, 0, 0, 8'h20, 8'h21, 0, 0, 0);
        v(0, 0, 1, 8'h21, 8'h22, 0, 0, 0);   // NOPF flag marks the call
        v(1, 0, 0, 8'h22, 8'h80, 1, 0, 0);   // push 0x23
        v(0, 0, 0, 8'h80, 8'h81, 1, 0, 0);
        v(0, 0, 0, 8'h81, 8'h82, 1, 0, 0);
        v(0, 0, 0, 8'h82, 8'h83, 1, 0, 0);
        v(0, 0, 0, 8'h83, 8'h84, 1, 0, 0);
        v(0, 0, 0, 8'h84, 8'h85, 1, 0, 0);
        v(0, 0, 0, 8'h85, 8'h86, 1, 0, 0);
        v(0, 1, 0, 8'h86, 8'h23, 0, 0, 0);   // return to 0x23
        v(0, 0, 0, 8'h23, 8'h24, 0, 0, 0);
        v(0, 0, 1, 8'h24, 8'h25, 0, 0, 0);
        v(1, 0, 0, 8'h25, 8'h30, 1, 0, 0);   // push 0x26
        v(0, 0, 0, 8'h30, 8'h31, 1, 0, 0);
        v(0, 0, 1, 8'h31, 8'h32, 1, 0, 0);
        v(1, 0, 0, 8'h32, 8'h50, 2, 0, 0);   // push 0x33
        v(0, 0, 0, 8'h50, 8'h51, 2, 0, 0);
        v(0, 0, 1, 8'h51, 8'h52, 2, 0, 0);
        v(1, 0, 0, 8'h52, 8'h60, 3, 0, 0);   // push 0x53
        v(0, 0, 0, 8'h60, 8'h61, 3, 0, 0);
        v(0, 0, 1, 8'h61, 8'h62, 3, 0, 0);
        v(1, 0, 0, 8'h62, 8'h70, 4, 0, 0);   // push 0x63, stack full
        v(0, 0, 0, 8'h70, 8'h71, 4, 0, 0);
        v(0, 0, 1, 8'h71, 8'h72, 4, 0, 0);
        v(1, 0, 0, 8'h72, 8'hFE, 4, 1, 0);   // fifth push dropped, jump taken
        v(0, 0, 0, 8'hFE, 8'hFF, 4, 1, 0);
        v(0, 0, 0, 8'hFF, 8'h00, 4, 1, 0);   // wrap
        v(0, 1, 0, 8'h00, 8'h63, 3, 1, 0);
        v(0, 1, 0, 8'h63, 8'h53, 2, 1, 0);
        v(0, 1, 0, 8'h53, 8'h33, 1, 1, 0);
        v(0, 1, 0, 8'h33, 8'h26, 0, 1, 0);
        v(0, 1, 0, 8'h26, 8'h27, 0, 1, 1);   // return on empty stack
        v(0, 0, 0, 8'h27, 8'h28, 0, 1, 1);
        v(0, 0, 1, 8'h28, 8'h29, 0, 1, 1);
        v(0, 0, 0, 8'h29, 8'h2A, 0, 1, 1);   // pending call lapses
        v(1, 0, 0, 8'h2A, 8'h8C, 0, 1, 1);   // target = 0x29^0xA5, no push
        v(0, 0, 1, 8'h8C, 8'h8D, 0, 1, 1);
        v(1, 1, 0, 8'h8D, 8'h8E, 0, 1, 1);   // rtn beats jmp, no push

        #12;
        check("reset pc",   prog_addr, 8'h00);
        check("reset io",   io_addr,   8'h00);
        check("reset sp",   sp_dbg,    3'd0);
        check("reset ovf",  stack_ovf, 1'b0);
        check("reset unf",  stack_unf, 1'b0);
        @(negedge clk_in);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(ST_FETCH, vecs[i].jmp, vecs[i].rtn, vecs[i].flgf);
            check($sformatf("v%0d pc", i),  prog_addr, vecs[i].pc);
            check($sformatf("v%0d io", i),  io_addr,   pmem[vecs[i].fetched][11:4]);
            check($sformatf("v%0d sp", i),  sp_dbg,    vecs[i].sp);
            check($sformatf("v%0d ovf", i), stack_ovf, vecs[i].ovf);
            check($sformatf("v%0d unf", i), stack_unf, vecs[i].unf);
            check($sformatf("v%0d I", i),   I,         pmem[vecs[i].pc][3:0]);
            step(ST_DECODE_EXECUTE, vecs[i].jmp, vecs[i].rtn, vecs[i].flgf);
            check($sformatf("v%0d hold pc", i), prog_addr, vecs[i].pc);
            check($sformatf("v%0d hold io", i), io_addr,   pmem[vecs[i].fetched][11:4]);
        end

        // Long execute phase with jmp asserted: nothing may move
        for (int k = 0; k < 4; k++) begin
            step(ST_DECODE_EXECUTE, 1'b1, 1'b0, 1'b0);
            check($sformatf("hold%0d pc", k), prog_addr, 8'h8E);
            check($sformatf("hold%0d io", k), io_addr,   8'h28);
        end
        step(ST_FETCH, 1'b0, 1'b0, 1'b0);
        check("after hold pc", prog_addr, 8'h8F);
        check("after hold io", io_addr,   8'h2B);

        // Build one stack entry, then leave a call pending
        step(ST_FETCH,          1'b0, 1'b0, 1'b1);
        step(ST_DECODE_EXECUTE, 1'b0, 1'b0, 1'b0);
        step(ST_FETCH,          1'b1, 1'b0, 1'b0);
        check("pre-reset call pc", prog_addr, 8'h2A);
        check("pre-reset call sp", sp_dbg,    3'd1);
        step(ST_DECODE_EXECUTE, 1'b0, 1'b0, 1'b0);
        step(ST_FETCH,          1'b0, 1'b0, 1'b1);
        step(ST_DECODE_EXECUTE, 1'b1, 1'b0, 1'b0);
        check("pre-reset pc", prog_addr, 8'h2B);

        // Asynchronous reset mid-execute, observed before any clock edge
        #2 rst = 1'b1;
        #1;
        check("async rst pc",  prog_addr, 8'h00);
        check("async rst io",  io_addr,   8'h00);
        check("async rst sp",  sp_dbg,    3'd0);
        check("async rst ovf", stack_ovf, 1'b0);
        check("async rst unf", stack_unf, 1'b0);
        @(negedge clk_in);
        rst = 1'b0;
        // jmp after reset: target register cleared, pending call gone
        step(ST_FETCH, 1'b1, 1'b0, 1'b0);
        check("post-rst jmp pc", prog_addr, 8'h00);
        check("post-rst jmp sp", sp_dbg,    3'd0);
        check("post-rst jmp io", io_addr,   8'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mc14500b_seq.md
Name: mc14500b_seq

Overview:
- Program sequencer sitting directly upstream of the mc14500b ICU.
- Holds the program counter and drives the program-memory address.
- Splits each program word into the 4-bit opcode (to ICU input I) and an operand field (I/O address / jump target).
- Resolves the ICU's JMP/RTN flags into PC loads, with a small return-address stack; call is marked by a NOPF immediately before a JMP.

Parameters:
- ADDR_W, 8, width of PC, jump target and I/O address.
- STACK_DEPTH, 4, return-stack entries (power of two, >=2).

Ports:
- clk_in, input, 1, single clock (same clock as the ICU).
- rst, input, 1, asynchronous active-high reset.
- prog_addr, output, ADDR_W, program memory address (= pc register).
- prog_data, input, 4+ADDR_W, program word; [3:0] opcode, [4+ADDR_W-1:4] operand.
- I, output, 4, opcode to ICU (combinational = prog_data[3:0]).
- io_addr, output, ADDR_W, operand latched for the instruction now executing.
- icu_state, input, 1, ICU state_out (0 = FETCH, 1 = DECODE_EXECUTE).
- jmp, input, 1, ICU JMP flag.
- rtn, input, 1, ICU RTN flag.
- flgf, input, 1, ICU FLGF flag.
- stack_ovf, output, 1, sticky: push attempted while stack full.
- stack_unf, output, 1, sticky: pop attempted while stack empty.
- sp_dbg, output, clog2(STACK_DEPTH)+1, current stack occupancy.

Behaviour:
- Reset (async, rst=1): pc=0, io_addr=0, tgt_reg=0, stack empty (sp=0), call_pending=0, stack_ovf=0, stack_unf=0.
- All state updates occur only on rising edges where icu_state=0 (FETCH edge). Edges with icu_state=1 hold every register.
- FETCH edge, base actions:
  - io_addr <= operand.
  - tgt_reg <= operand.
  - pc <= next_pc.
- next_pc priority:
  - rtn=1 and stack non-empty: pop top.
  - rtn=1 and stack empty: pc+1, stack_unf <= 1.
  - jmp=1: tgt_reg (old value = operand of the JMP word).
  - else: pc+1.
- PC arithmetic is modulo 2^ADDR_W; pc = all-ones wraps to 0.
- Jump timing: JMP at address A. The word at A+1 is fetched in the same FETCH cycle that sees jmp=1, so it is a delay slot and executes. The next fetch is at the target.
- Call:
  - call_pending <= 1 on a FETCH edge with flgf=1.
  - On a FETCH edge with jmp=1 and call_pending=1: push A+2 (= current pc+1, the address after the delay slot), then clear call_pending.
  - On any FETCH edge with flgf=0 and jmp=0, call_pending clears.
  - Push when full: entry dropped, stack unchanged, stack_ovf <= 1, jump still taken.
- Return timing: the ICU skips the word fetched in the cycle where rtn=1. The sequencer still advances pc to the popped address on that edge.
- jmp and rtn are never both 1 from a legal ICU. If they are, rtn wins and no push occurs.
- Stack is LIFO with pointer 0..STACK_DEPTH; push and pop never occur on the same edge.
- Sticky flags clear only on reset.
- Reset mid-instruction: everything returns to reset values immediately, including a pending call and the stack contents.

Decomposition:
- Shared package mc14500_pkg: the 4-bit opcode localparams (NOPO..NOPF), FETCH/DECODE_EXECUTE state constants, program-word field offsets.
- One sub-module: mc14500b_rstack (LIFO, parameters ADDR_W/STACK_DEPTH; push/pop/full/empty/top/ovf/unf).

Test Plan:
- Reset then free run with all-LD program: prog_addr steps 0,1,2… once per two clocks; io_addr tracks operand; pc wraps 255->0 (ADDR_W=8).
- JMP 0x40 at 0x10: word 0x11 fetched (delay slot), next fetch at 0x40; stack unchanged (sp_dbg=0).
- NOPF at 0x20, JMP 0x80 at 0x21: push 0x23, fetch 0x22 then 0x80; later RTN at 0x85 -> next fetch at 0x23, sp_dbg back to 0.
- Five nested calls with STACK_DEPTH=4: fifth push dropped, stack_ovf=1, jump still taken; RTN with empty stack -> pc+1, stack_unf=1.
- Assert rst during DECODE_EXECUTE of a pending call: prog_addr=0, sp_dbg=0, flags 0 asynchronously, before the next clock edge.
- Hold icu_state=1 for several edges with jmp=1: pc/io_addr unchanged until the next FETCH edge.
